reflet_input_capture: RTL and testbench
=======================================

REFLET_INPUT_CAPTURE -- requirements
Module: reflet_input_capture

Interface
REQ-001 SHALL have parameter base_addr_size, default 16, width of the system-bus address.
REQ-002 SHALL have parameter base_addr, default 16'hFF20, address of the first of four byte registers.
REQ-003 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, bus-access qualifier; when low, no register is read or written.
REQ-006 SHALL have port addr, input, base_addr_size, system-bus byte address.
REQ-007 SHALL have port write_en, input, 1, write strobe, valid with enable.
REQ-008 SHALL have port data_in, input, 8, write data.
REQ-009 SHALL have port data_out, output, 8, combinational read data; 8'h00 whenever not addressed, so the bus can OR it.
REQ-010 SHALL have port capture_input, input, 1, asynchronous external signal to measure.
REQ-011 SHALL have port interrupt, output, 1, level interrupt.

Function
REQ-012 SHALL decode offset = addr - base_addr when enable is high and base_addr <= addr < base_addr+4.
REQ-013 SHALL make offset 0 CTRL read/write: bit0 EN, bit1 EDGE (0 rising, 1 falling), bit2 IE, bits7:3 PRE.
REQ-014 SHALL make offset 1 STATUS: bit0 VALID, bit1 OVF, bit2 MISSED, bits7:3 read 0; a write clears each bit where data_in is 1 (W1C).
REQ-015 SHALL make an offset 2 read return capture[7:0] and, in the same cycle, latch capture[15:8] into an 8-bit shadow.
REQ-016 SHALL make an offset 3 read return the shadow and clear VALID on that clock edge; writes to offsets 2 and 3 are ignored.
REQ-017 SHALL pass capture_input through a two-flop synchroniser plus a previous-value flop; an edge is sync2 differing from prev in the EDGE-selected direction.
REQ-018 SHALL set VALID exactly 3 clk cycles after a capture_input transition that meets setup before the first sampling edge.
REQ-019 SHALL run a 5-bit prescaler that produces one tick every PRE+1 clocks, and a 16-bit period counter that increments on each tick.
REQ-020 SHALL saturate the period counter at 16'hFFFF and set an internal sticky ovf_pending flag when saturated.
REQ-021 SHALL set an armed flag on the first detected edge after EN rises, load counter=1 and prescaler=0, and make no capture on that edge.
REQ-022 SHALL, on each detected edge while armed: capture <= counter; OVF <= ovf_pending; MISSED <= MISSED|VALID; VALID <= 1; counter <= 1; prescaler <= 0; ovf_pending <= 0.
REQ-023 SHALL yield capture = 1 + floor((P-1)/(PRE+1)) for edges P clocks apart, i.e. capture = P when PRE=0.
REQ-024 SHALL, while EN is 0, hold the counter, prescaler, armed and ovf_pending at 0, ignore edges, and retain capture and STATUS.
REQ-025 SHALL let a capture win over a same-cycle W1C of VALID or an offset-3 read, leaving VALID at 1.
REQ-026 SHALL drive interrupt = IE & VALID, combinationally from registered state.

Reset
REQ-027 SHALL, on reset low, asynchronously clear CTRL, STATUS, capture, shadow, the counter, prescaler, armed, ovf_pending and the synchroniser flops; interrupt is 0.
REQ-028 SHALL, with reset asserted mid-measurement, discard that measurement; after release the first edge only arms the block.

Verification
REQ-029 SHALL cover this case: CTRL=8'h05, rising edges 100 clocks apart ×3 -> after the 2nd edge, CAP_L=8'h64 and CAP_H=8'h00, VALID=1, interrupt=1; reading offset 3 -> VALID=0, interrupt=0.
REQ-030 SHALL cover this case: CTRL=8'h19 (PRE=3), edges 40 clocks apart -> capture=10 (16'h000A).
REQ-031 SHALL cover this case: CTRL=8'h01, edges 70000 clocks apart -> capture=16'hFFFF, OVF=1; writing STATUS=8'h02 -> OVF=0.
REQ-032 SHALL cover this case: three edges without reading -> MISSED=1 and capture holds the latest period; CAP_H read between captures returns the shadow latched at the CAP_L read.
REQ-033 SHALL cover this case: CTRL=8'h03 (falling) -> rising edges ignored and falling edges captured; W1C of VALID in the capture cycle -> VALID stays 1.
REQ-034 SHALL cover this case: reset pulsed mid-period, then EN set again -> all registers 0, interrupt=0, first post-reset edge produces no capture.

Source files
------------

// File: rtl/reflet_input_capture.sv
`timescale 1ns/1ps
// Input-capture peripheral: measures the prescaled period between selected edges
// of an asynchronous input, exposed as four byte registers on the system bus.
module reflet_input_capture #(
    parameter int unsigned                base_addr_size = 16,
    parameter logic [base_addr_size-1:0]  base_addr      = 16'hFF20
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [base_addr_size-1:0] addr,
    input  logic                      write_en,
    input  logic [7:0]                data_in,
    output logic [7:0]                data_out,
    input  logic                      capture_input,
    output logic                      interrupt
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PRE_W = 5;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_STATUS = 2'd1;
    localparam logic [1:0] OFF_CAP_L  = 2'd2;
    localparam logic [1:0] OFF_CAP_H  = 2'd3;

    // Register state
    logic [7:0]       ctrl_q, ctrl_d;
    logic             valid_q, valid_d;
    logic             ovf_q, ovf_d;
    logic             missed_q, missed_d;
    logic [CNT_W-1:0] cap_q, cap_d;
    logic [7:0]       shadow_q, shadow_d;

    // Measurement state
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [PRE_W-1:0] presc_q, presc_d;
    logic             armed_q, armed_d;
    logic             ovf_pend_q, ovf_pend_d;

    // Synchroniser and edge-history flops
    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;

    // Bus decode
    logic [base_addr_size-1:0] offset;
    logic [1:0]                off;
    logic                      hit;
    logic                      rd;
    logic                      wr;

    // Control fields and edge qualifiers
    logic             cap_en;
    logic             edge_fall;
    logic             irq_en;
    logic [PRE_W-1:0] pre;
    logic             rise_det;
    logic             fall_det;
    logic             edge_det;
    logic             do_cap;
    logic             tick;

    // Out-of-window addresses wrap to large offsets, so one compare covers both bounds
    always_comb begin
        offset = addr - base_addr;
        off    = offset[1:0];
        hit    = enable && (offset < base_addr_size'(4));
        rd     = hit && !write_en;
        wr     = hit && write_en;
    end

    always_comb begin
        cap_en    = ctrl_q[0];
        edge_fall = ctrl_q[1];
        irq_en    = ctrl_q[2];
        pre       = ctrl_q[7:3];
    end

    always_comb begin
        sync1_d  = capture_input;
        sync2_d  = sync1_q;
        prev_d   = sync2_q;
        rise_det = sync2_q && !prev_q;
        fall_det = !sync2_q && prev_q;
        edge_det = cap_en && (edge_fall ? fall_det : rise_det);
        do_cap   = edge_det && armed_q;
    end

    // Period counter: the first edge after enabling only arms, later edges restart the count
    always_comb begin
        cnt_d      = cnt_q;
        presc_d    = presc_q;
        armed_d    = armed_q;
        ovf_pend_d = ovf_pend_q;
        tick       = (presc_q >= pre);
        if (!cap_en) begin
            cnt_d      = '0;
            presc_d    = '0;
            armed_d    = 1'b0;
            ovf_pend_d = 1'b0;
        end else if (edge_det) begin
            cnt_d      = CNT_W'(1);
            presc_d    = '0;
            armed_d    = 1'b1;
            ovf_pend_d = 1'b0;
        end else if (armed_q) begin
            if (cnt_q == {CNT_W{1'b1}}) begin
                ovf_pend_d = 1'b1;
            end
            if (tick) begin
                presc_d = '0;
                if (cnt_q != {CNT_W{1'b1}}) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else begin
                presc_d = presc_q + PRE_W'(1);
            end
        end
    end

    // Bus-side register updates; a capture overrides a same-cycle clear of STATUS
    always_comb begin
        ctrl_d   = ctrl_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        missed_d = missed_q;
        cap_d    = cap_q;
        shadow_d = shadow_q;
        if (wr && (off == OFF_CTRL)) begin
            ctrl_d = data_in;
        end
        if (wr && (off == OFF_STATUS)) begin
            valid_d  = valid_q  && !data_in[0];
            ovf_d    = ovf_q    && !data_in[1];
            missed_d = missed_q && !data_in[2];
        end
        if (rd && (off == OFF_CAP_L)) begin
            shadow_d = cap_q[15:8];
        end
        if (rd && (off == OFF_CAP_H)) begin
            valid_d = 1'b0;
        end
        if (do_cap) begin
            cap_d    = cnt_q;
            ovf_d    = ovf_pend_q;
            missed_d = missed_q || valid_q;
            valid_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q     <= '0;
            valid_q    <= 1'b0;
            ovf_q      <= 1'b0;
            missed_q   <= 1'b0;
            cap_q      <= '0;
            shadow_q   <= '0;
            cnt_q      <= '0;
            presc_q    <= '0;
            armed_q    <= 1'b0;
            ovf_pend_q <= 1'b0;
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            prev_q     <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            valid_q    <= valid_d;
            ovf_q      <= ovf_d;
            missed_q   <= missed_d;
            cap_q      <= cap_d;
            shadow_q   <= shadow_d;
            cnt_q      <= cnt_d;
            presc_q    <= presc_d;
            armed_q    <= armed_d;
            ovf_pend_q <= ovf_pend_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            prev_q     <= prev_d;
        end
    end

    // Read data is zero off-window so several peripherals can be OR-ed onto the bus
    always_comb begin
        data_out = 8'h00;
        if (hit) begin
            case (off)
                OFF_CTRL:   data_out = ctrl_q;
                OFF_STATUS: data_out = {5'b00000, missed_q, ovf_q, valid_q};
                OFF_CAP_L:  data_out = cap_q[7:0];
                OFF_CAP_H:  data_out = shadow_q;
                default:    data_out = 8'h00;
            endcase
        end
    end

    assign interrupt = irq_en && valid_q;

endmodule

// File: tb/tb_reflet_input_capture.sv
`timescale 1ns/1ps
// Directed bench for reflet_input_capture: edge periods, prescaler, overflow,
// missed captures, falling-edge mode, capture/clear collisions and reset.
module tb_reflet_input_capture;

    localparam int unsigned  AW   = 16;
    localparam logic [AW-1:0] BASE = 16'hFF20;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [AW-1:0] addr;
    logic          write_en;
    logic [7:0]    data_in;
    logic [7:0]    data_out;
    logic          capture_input;
    logic          interrupt;

    int n_checks  = 0;
    int n_fail    = 0;
    int cyc       = 0;
    int last_edge = 0;
    logic [7:0] rdata;

    reflet_input_capture #(
        .base_addr_size (AW),
        .base_addr      (BASE)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .addr          (addr),
        .write_en      (write_en),
        .data_in       (data_in),
        .data_out      (data_out),
        .capture_input (capture_input),
        .interrupt     (interrupt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // All bus tasks start just after a falling edge and take exactly one clock
    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] off, input logic [7:0] d);
        enable   = 1'b1;
        write_en = 1'b1;
        addr     = BASE + AW'(off);
        data_in  = d;
        @(negedge clk);
        enable   = 1'b0;
        write_en = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] off, output logic [7:0] d);
        enable   = 1'b1;
        write_en = 1'b0;
        addr     = BASE + AW'(off);
        #1 d = data_out;
        @(negedge clk);
        enable   = 1'b0;
    endtask

    task automatic read_check(input logic [1:0] off, input logic [7:0] exp, input string tag);
        logic [7:0] d;
        bus_read(off, d);
        check_eq(tag, {8'h00, d}, {8'h00, exp});
    endtask

    // Drives the opposite level halfway, then the selected level gap clocks after the last edge
    task automatic next_edge(input int gap, input logic lvl);
        wait_until(last_edge + gap / 2);
        capture_input = ~lvl;
        wait_until(last_edge + gap);
        capture_input = lvl;
        last_edge     = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset         = 1'b0;
        enable        = 1'b0;
        addr          = BASE;
        write_en      = 1'b0;
        data_in       = 8'h00;
        capture_input = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_eq("irq_reset", 16'(interrupt), 16'h0);
        reset = 1'b1;
        @(negedge clk);

        read_check(2'd0, 8'h00, "ctrl_reset");
        read_check(2'd1, 8'h00, "status_reset");
        read_check(2'd2, 8'h00, "capl_reset");
        read_check(2'd3, 8'h00, "caph_reset");

        // Decode boundaries and enable qualification
        bus_write(2'd0, 8'h05);
        read_check(2'd0, 8'h05, "ctrl_wr");
        enable = 1'b1; addr = BASE + AW'(4);
        #1 check_eq("dout_above", 16'(data_out), 16'h0);
        addr = BASE - AW'(1);
        #1 check_eq("dout_below", 16'(data_out), 16'h0);
        addr = BASE; enable = 1'b0;
        #1 check_eq("dout_en_low", 16'(data_out), 16'h0);
        write_en = 1'b1; data_in = 8'hFF;
        @(negedge clk);
        write_en = 1'b0;
        read_check(2'd0, 8'h05, "ctrl_en_low_wr");

        // Rising edges 100 clocks apart with IE set
        last_edge = cyc;
        next_edge(20, 1'b1);
        next_edge(100, 1'b1);
        wait_until(last_edge + 2);
        read_check(2'd1, 8'h00, "valid_lat2");
        check_eq("irq_cap1", 16'(interrupt), 16'h1);
        read_check(2'd1, 8'h01, "status_cap1");
        read_check(2'd2, 8'h64, "capl_100");
        read_check(2'd3, 8'h00, "caph_100");
        #1 check_eq("irq_after_h", 16'(interrupt), 16'h0);
        read_check(2'd1, 8'h00, "status_after_h");
        next_edge(100, 1'b1);
        wait_until(last_edge + 3);
        read_check(2'd1, 8'h01, "status_cap2");
        read_check(2'd2, 8'h64, "capl_100b");

        // Unread captures set MISSED; CAP_H returns the byte latched at the CAP_L read
        next_edge(300, 1'b1);
        wait_until(last_edge + 3);
        read_check(2'd3, 8'h00, "caph_shadow");
        read_check(2'd1, 8'h04, "status_missed");
        next_edge(336, 1'b1);
        wait_until(last_edge + 3);
        read_check(2'd1, 8'h05, "status_missed2");
        read_check(2'd2, 8'h50, "capl_336");
        read_check(2'd3, 8'h01, "caph_336");
        bus_write(2'd1, 8'h04);
        read_check(2'd1, 8'h00, "status_w1c");

        // Prescaler PRE=3
        bus_write(2'd0, 8'h00);
        bus_write(2'd0, 8'h19);
        read_check(2'd0, 8'h19, "ctrl_pre3");
        last_edge = cyc;
        next_edge(20, 1'b1);
        next_edge(40, 1'b1);
        wait_until(last_edge + 3);
        #1 check_eq("irq_ie_off", 16'(interrupt), 16'h0);
        read_check(2'd2, 8'h0A, "capl_pre40");
        read_check(2'd3, 8'h00, "caph_pre40");
        next_edge(41, 1'b1);
        wait_until(last_edge + 3);
        read_check(2'd2, 8'h0B, "capl_pre41");

        // Falling-edge mode and capture/clear collisions
        bus_write(2'd0, 8'h00);
        bus_write(2'd1, 8'h07);
        bus_write(2'd0, 8'h03);
        last_edge = cyc;
        next_edge(20, 1'b0);
        next_edge(60, 1'b0);
        wait_until(last_edge + 3);
        read_check(2'd1, 8'h01, "status_fall");
        read_check(2'd2, 8'h3C, "capl_fall60");
        read_check(2'd3, 8'h00, "caph_fall60");
        next_edge(50, 1'b0);
        wait_until(last_edge + 2);
        bus_write(2'd1, 8'h01);
        read_check(2'd1, 8'h01, "valid_vs_w1c");
        read_check(2'd2, 8'h32, "capl_fall50");
        next_edge(45, 1'b0);
        wait_until(last_edge + 2);
        read_check(2'd3, 8'h00, "caph_collide");
        read_check(2'd1, 8'h05, "valid_vs_rd3");
        read_check(2'd2, 8'h2D, "capl_fall45");

        // Counter saturation
        bus_write(2'd0, 8'h00);
        bus_write(2'd1, 8'h07);
        bus_write(2'd0, 8'h01);
        last_edge = cyc;
        next_edge(20, 1'b1);
        next_edge(70000, 1'b1);
        wait_until(last_edge + 3);
        read_check(2'd1, 8'h03, "status_ovf");
        bus_write(2'd1, 8'h02);
        read_check(2'd1, 8'h01, "status_ovf_clr");
        read_check(2'd2, 8'hFF, "capl_sat");
        read_check(2'd3, 8'hFF, "caph_sat");
        read_check(2'd1, 8'h00, "status_sat_rd");

        // Reset in the middle of a period
        bus_write(2'd0, 8'h00);
        bus_write(2'd0, 8'h05);
        last_edge = cyc;
        next_edge(20, 1'b1);
        next_edge(80, 1'b1);
        wait_until(last_edge + 3);
        #1 check_eq("irq_pre_rst", 16'(interrupt), 16'h1);
        wait_until(last_edge + 30);
        #2 reset = 1'b0;
        #1 check_eq("irq_async_rst", 16'(interrupt), 16'h0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        read_check(2'd0, 8'h00, "ctrl_rst2");
        read_check(2'd1, 8'h00, "status_rst2");
        read_check(2'd2, 8'h00, "capl_rst2");
        read_check(2'd3, 8'h00, "caph_rst2");
        bus_write(2'd0, 8'h05);
        last_edge = cyc;
        next_edge(20, 1'b1);
        wait_until(last_edge + 3);
        read_check(2'd1, 8'h00, "status_arm_only");
        #1 check_eq("irq_arm_only", 16'(interrupt), 16'h0);
        next_edge(50, 1'b1);
        wait_until(last_edge + 3);
        #1 check_eq("irq_post_rst", 16'(interrupt), 16'h1);
        read_check(2'd1, 8'h01, "status_post_rst");
        read_check(2'd2, 8'h32, "capl_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
